// File: rtl/time_set_keeper.sv
// Keypad time-setting consumer: assembles two-digit BCD entries per field, range-checks
// them on the completeSetting rising edge, loads HH:MM:SS and advances it on a 1 Hz tick.
module time_set_keeper #(
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       reset,
  input  logic       clock,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       hour_en,
  input  logic       min_en,
  input  logic       sec_en,
  input  logic       completeSetting,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       load_pulse,
  output logic       set_error
);

  localparam logic [7:0] HourMaxBcd = 8'(((HOUR_MAX / 10) << 4) | (HOUR_MAX % 10));

  typedef enum logic {StEntry, StCommit} state_e;

  state_e     r_state, w_state_next;
  logic       r_cs_prev;
  logic [7:0] r_hour, r_min, r_sec;
  logic [7:0] r_entry_h, r_entry_m, r_entry_s;
  logic [1:0] r_cnt_h, r_cnt_m, r_cnt_s;
  logic       r_running, r_load_pulse, r_set_error;

  logic       w_cs_rise, w_key_ok, w_cap_h, w_cap_m, w_cap_s;
  logic [7:0] w_cand_h, w_cand_m, w_cand_s;
  logic       w_valid, w_do_load, w_do_tick;
  logic       w_sec_wrap, w_min_wrap, w_hour_wrap;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = v[7:4];
    lo = v[3:0];
    if (lo == 4'd9) bcd_inc = {hi + 4'd1, 4'd0};
    else            bcd_inc = {hi, lo + 4'd1};
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    sat_inc = (c == 2'd2) ? 2'd2 : c + 2'd1;
  endfunction

  assign w_cs_rise = completeSetting & ~r_cs_prev;

  // Keys are only taken in ENTRY; one field captures per key, hour > min > sec.
  assign w_key_ok = key_valid & (key_digit <= 4'd9) & (r_state == StEntry);
  assign w_cap_h  = w_key_ok & hour_en;
  assign w_cap_m  = w_key_ok & ~hour_en & min_en;
  assign w_cap_s  = w_key_ok & ~hour_en & ~min_en & sec_en;

  assign w_cand_h = (r_cnt_h == 2'd0) ? r_hour : r_entry_h;
  assign w_cand_m = (r_cnt_m == 2'd0) ? r_min  : r_entry_m;
  assign w_cand_s = (r_cnt_s == 2'd0) ? r_sec  : r_entry_s;
  assign w_valid  = (w_cand_h <= HourMaxBcd) & (w_cand_m <= 8'h59) & (w_cand_s <= 8'h59);

  assign w_do_load = (r_state == StCommit) & w_valid;
  assign w_do_tick = tick & r_running & ~w_do_load;

  assign w_sec_wrap  = (r_sec == 8'h59);
  assign w_min_wrap  = (r_min == 8'h59);
  assign w_hour_wrap = (r_hour == HourMaxBcd);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StEntry:  if (w_cs_rise) w_state_next = StCommit;
      StCommit: w_state_next = StEntry;
      default:  w_state_next = StEntry;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= StEntry;
      r_cs_prev    <= 1'b0;
      r_hour       <= 8'h00;
      r_min        <= 8'h00;
      r_sec        <= 8'h00;
      r_entry_h    <= 8'h00;
      r_entry_m    <= 8'h00;
      r_entry_s    <= 8'h00;
      r_cnt_h      <= 2'd0;
      r_cnt_m      <= 2'd0;
      r_cnt_s      <= 2'd0;
      r_running    <= 1'b0;
      r_load_pulse <= 1'b0;
      r_set_error  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cs_prev    <= completeSetting;
      r_load_pulse <= 1'b0;

      if (w_cap_h) begin
        r_entry_h <= {r_entry_h[3:0], key_digit};
        r_cnt_h   <= sat_inc(r_cnt_h);
      end
      if (w_cap_m) begin
        r_entry_m <= {r_entry_m[3:0], key_digit};
        r_cnt_m   <= sat_inc(r_cnt_m);
      end
      if (w_cap_s) begin
        r_entry_s <= {r_entry_s[3:0], key_digit};
        r_cnt_s   <= sat_inc(r_cnt_s);
      end
      if (w_cap_h | w_cap_m | w_cap_s) r_set_error <= 1'b0;

      if (r_state == StCommit) begin
        r_entry_h   <= 8'h00;
        r_entry_m   <= 8'h00;
        r_entry_s   <= 8'h00;
        r_cnt_h     <= 2'd0;
        r_cnt_m     <= 2'd0;
        r_cnt_s     <= 2'd0;
        r_set_error <= ~w_valid;
      end

      if (w_do_load) begin
        r_hour       <= w_cand_h;
        r_min        <= w_cand_m;
        r_sec        <= w_cand_s;
        r_running    <= 1'b1;
        r_load_pulse <= 1'b1;
      end else if (w_do_tick) begin
        r_sec <= w_sec_wrap ? 8'h00 : bcd_inc(r_sec);
        if (w_sec_wrap) begin
          r_min <= w_min_wrap ? 8'h00 : bcd_inc(r_min);
          if (w_min_wrap) r_hour <= w_hour_wrap ? 8'h00 : bcd_inc(r_hour);
        end
      end
    end
  end

  assign hour_bcd   = r_hour;
  assign min_bcd    = r_min;
  assign sec_bcd    = r_sec;
  assign running    = r_running;
  assign load_pulse = r_load_pulse;
  assign set_error  = r_set_error;

endmodule

// File: tb/tb_time_set_keeper.sv
// Directed bench for time_set_keeper: table of setting transactions plus hand-written
// sequences for reset, key filtering, tick/commit collision and async reset mid-entry.
module tb_time_set_keeper;

  logic       reset, clock, tick, key_valid;
  logic [3:0] key_digit;
  logic       hour_en, min_en, sec_en, completeSetting;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic       running, load_pulse, set_error;

  int n_cmp = 0;
  int n_bad = 0;

  time_set_keeper #(.HOUR_MAX(23)) dut (
    .reset          (reset),
    .clock          (clock),
    .tick           (tick),
    .key_valid      (key_valid),
    .key_digit      (key_digit),
    .hour_en        (hour_en),
    .min_en         (min_en),
    .sec_en         (sec_en),
    .completeSetting(completeSetting),
    .hour_bcd       (hour_bcd),
    .min_bcd        (min_bcd),
    .sec_bcd        (sec_bcd),
    .running        (running),
    .load_pulse     (load_pulse),
    .set_error      (set_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         nh;
    logic [7:0] h;
    int         nm;
    logic [7:0] m;
    int         ns;
    logic [7:0] s;
    int         ntick;
    logic [7:0] eh;
    logic [7:0] em;
    logic [7:0] es;
    logic       eerr;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_time(input string name, input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    chk(name, {8'h00, hour_bcd, min_bcd, sec_bcd}, {8'h00, h, m, s});
  endtask

  task automatic key(input logic h, input logic m, input logic s, input logic [3:0] d);
    hour_en = h; min_en = m; sec_en = s; key_valid = 1'b1; key_digit = d;
    @(negedge clock);
    hour_en = 1'b0; min_en = 1'b0; sec_en = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
  endtask

  task automatic enter(input int f, input int n, input logic [7:0] v);
    if (n == 2) key(f == 0, f == 1, f == 2, v[7:4]);
    if (n >= 1) key(f == 0, f == 1, f == 2, v[3:0]);
  endtask

  // Holds completeSetting for 10 cycles; returns how many sampled cycles had load_pulse.
  task automatic commit(input logic with_tick, output int pulses);
    pulses = 0;
    completeSetting = 1'b1;
    tick = with_tick;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 1) tick = 1'b0;
      if (load_pulse) pulses++;
    end
    completeSetting = 1'b0;
    tick = 1'b0;
    @(negedge clock);
    if (load_pulse) pulses++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    vecs[0] = '{2, 8'h12, 2, 8'h34, 2, 8'h56, 1, 8'h12, 8'h34, 8'h57, 1'b0};
    vecs[1] = '{2, 8'h23, 2, 8'h59, 2, 8'h59, 1, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{2, 8'h09, 2, 8'h59, 2, 8'h59, 1, 8'h10, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{2, 8'h25, 0, 8'h00, 0, 8'h00, 0, 8'h10, 8'h00, 8'h00, 1'b1};
    vecs[4] = '{2, 8'h10, 2, 8'h20, 2, 8'h30, 0, 8'h10, 8'h20, 8'h30, 1'b0};
    vecs[5] = '{0, 8'h00, 1, 8'h07, 0, 8'h00, 0, 8'h10, 8'h07, 8'h30, 1'b0};
    vecs[6] = '{0, 8'h00, 2, 8'h60, 0, 8'h00, 0, 8'h10, 8'h07, 8'h30, 1'b1};
    vecs[7] = '{0, 8'h00, 0, 8'h00, 2, 8'h59, 1, 8'h10, 8'h08, 8'h00, 1'b0};
    vecs[8] = '{2, 8'h24, 0, 8'h00, 0, 8'h00, 0, 8'h10, 8'h08, 8'h00, 1'b1};

    reset = 1'b1; tick = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    hour_en = 1'b0; min_en = 1'b0; sec_en = 1'b0; completeSetting = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state, and ticks before any load must not count
    chk_time("reset_time", 8'h00, 8'h00, 8'h00);
    chk("reset_flags", {29'd0, running, load_pulse, set_error}, 32'd0);
    repeat (3) do_tick();
    chk_time("idle_ticks", 8'h00, 8'h00, 8'h00);
    chk("idle_running", {31'd0, running}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      enter(0, vecs[i].nh, vecs[i].h);
      enter(1, vecs[i].nm, vecs[i].m);
      enter(2, vecs[i].ns, vecs[i].s);
      commit(1'b0, p);
      chk($sformatf("v%0d_pulses", i), p, vecs[i].eerr ? 0 : 1);
      chk($sformatf("v%0d_err", i), {31'd0, set_error}, {31'd0, vecs[i].eerr});
      for (int t = 0; t < vecs[i].ntick; t++) do_tick();
      chk_time($sformatf("v%0d_time", i), vecs[i].eh, vecs[i].em, vecs[i].es);
      chk($sformatf("v%0d_running", i), {31'd0, running}, 32'd1);
    end

    // Accepted digit clears set_error; hour wins over min; bad code and no-enable keys ignored
    key(1'b1, 1'b1, 1'b0, 4'd1);
    chk("err_cleared", {31'd0, set_error}, 32'd0);
    key(1'b0, 1'b1, 1'b0, 4'd11);
    key(1'b0, 1'b0, 1'b0, 4'd5);
    commit(1'b0, p);
    chk("filter_pulses", p, 1);
    chk_time("filter_time", 8'h01, 8'h08, 8'h00);

    // Tick overlapping a valid commit is dropped
    enter(0, 2, 8'h01);
    enter(1, 2, 8'h02);
    enter(2, 2, 8'h03);
    commit(1'b1, p);
    chk("tickload_pulses", p, 1);
    chk_time("tickload_time", 8'h01, 8'h02, 8'h03);

    // Async reset mid-entry clears everything at once; pending entry lost
    key(1'b1, 1'b0, 1'b0, 4'd1);
    key(1'b1, 1'b0, 1'b0, 4'd2);
    #2 reset = 1'b1;
    #1;
    chk_time("async_reset_time", 8'h00, 8'h00, 8'h00);
    chk("async_reset_flags", {29'd0, running, load_pulse, set_error}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    commit(1'b0, p);
    chk("post_reset_pulses", p, 1);
    chk_time("post_reset_time", 8'h00, 8'h00, 8'h00);
    chk("post_reset_running", {31'd0, running}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_set_keeper.md
Name: time_set_keeper

Overview:
- Consumer end of the keypad time-setting handshake.
- Receives the field enables (hour_en / min_en / sec_en) and the completeSetting flag from the setting FSM, together with keypad digits.
- Assembles two-digit BCD entries per field, range-checks them on completion, loads them into the running HH:MM:SS timekeeper, and advances time on an external 1 Hz tick.
- Feeds the display and alarm-compare logic.

Parameters:
- HOUR_MAX, 23, highest valid hour value (decimal); hour wraps HOUR_MAX -> 00.

Ports:
- reset  in  1  asynchronous, active-high reset
- clock  in  1  system clock
- tick  in  1  one-cycle 1 Hz strobe
- key_valid  in  1  one-cycle strobe, key_digit valid
- key_digit  in  4  keypad digit 0-9; codes 10-15 are ignored
- hour_en  in  1  hour field selected for entry
- min_en  in  1  minute field selected for entry
- sec_en  in  1  second field selected for entry
- completeSetting  in  1  setting sequence finished (level, may stay high)
- hour_bcd  out  8  current hour, two BCD digits
- min_bcd  out  8  current minute, two BCD digits
- sec_bcd  out  8  current second, two BCD digits
- running  out  1  time has been loaded at least once since reset
- load_pulse  out  1  one cycle high when a setting is committed
- set_error  out  1  sticky flag: last commit rejected

Behaviour:
- Reset (async, active-high):
  - hour/min/sec_bcd = 8'h00; running = 0; load_pulse = 0; set_error = 0.
  - All entry registers = 0; all digit counts = 0; state = ENTRY.
- Entry capture, per field F in {hour, min, sec}:
  - When F_en = 1 and key_valid = 1 and key_digit <= 9: entry_F <= {entry_F[3:0], key_digit}; cnt_F <= min(cnt_F + 1, 2).
  - Priority if more than one enable is high: hour > min > sec. Only one field captures per key.
  - A key with no enable high, or with key_digit > 9, is ignored.
  - Any accepted digit clears set_error on the next edge.
  - Exactly one digit entered (cnt_F = 1): value is 0 followed by that digit, e.g. key 7 -> 8'h07.
- Commit:
  - Triggered on the rising edge of completeSetting, registered: previous sample 0, current sample 1.
  - A level held high produces no repeat commit. Re-arming requires completeSetting to return to 0.
  - Each field with cnt_F = 0 keeps its current time value. Otherwise the candidate is entry_F.
  - Valid if hour candidate <= HOUR_MAX, min <= 59 and sec <= 59, all in BCD.
  - If valid: load all three fields; running = 1; load_pulse = 1 for exactly one cycle (the cycle after the edge is detected); set_error = 0.
  - If invalid: time is unchanged; set_error = 1; no load_pulse.
  - Either outcome: entries and counts are cleared.
- States:
  - ENTRY: capture digits. The rising edge of completeSetting moves to COMMIT.
  - COMMIT: one cycle; evaluate and load/reject, then go to ENTRY.
- Timekeeping, only while running = 1:
  - Each tick: sec + 1 in BCD (x9 -> (x+1)0).
  - sec 59 -> 00 with carry to min; min 59 -> 00 with carry to hour; hour HOUR_MAX -> 00.
  - Increment completes in the cycle tick is sampled; latency 1 clock.
  - Time keeps running during digit entry; entries are independent of the displayed time.
- Simultaneous events:
  - Tick in the same cycle as a valid commit: the load wins and that tick is dropped.
  - Tick with an invalid commit: the tick is applied normally.
  - key_valid in the COMMIT cycle: ignored.
- Reset mid-entry or mid-count: everything returns to reset values immediately; a pending commit is lost.

Test Plan:
- Reset then 3 ticks -> all outputs 00:00:00, running = 0, no increment.
- hour_en: keys 1,2; min_en: keys 3,4; sec_en: keys 5,6; raise completeSetting -> 12:34:56, load_pulse high exactly 1 cycle, running = 1. One tick -> 12:34:57.
- Load 23:59:59 then one tick -> 00:00:00. Load 09:59:59, tick -> 10:00:00.
- hour_en: keys 2,5, complete -> set_error = 1, time unchanged, no load_pulse. Next accepted digit -> set_error = 0.
- Entry of only min_en key 7 while at 10:20:30, complete -> 10:07:30. A digit 11 keyed and a digit keyed with no enable high -> ignored.
- Tick coincident with a valid commit of 01:02:03 -> reads 01:02:03 (tick dropped). completeSetting held high 10 cycles -> single load_pulse. Reset asserted mid-entry -> all outputs 0 at once.
